// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALU op encodings and MEM/WB control bundle for the MIPS core
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    typedef enum logic [2:0] {
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110
    } alu_op_t;
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } memwb_ctrl_t;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: beq/bne taken decision from the ALU zero flag, shared with the ID early-branch unit
module branch_resolve (
    input  logic branch,
    input  logic zero,
    input  logic branch_ne,
    output logic taken
);
    assign taken = branch & (zero ^ branch_ne);
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch resolution, stall/flush/squash and forwarding tap; optional overflow trap via EX_MEM_OVF_TRAP_EN
module ex_mem_stage #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              stall,
    input  logic              flush,
`ifdef EX_MEM_OVF_TRAP_EN
    input  logic              alu_overflow,
    input  logic              trap_en,
    input  logic [DATA_W-1:0] pc_in,
    output logic              exc_overflow,
    output logic [DATA_W-1:0] epc,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_W-1:0]  out_dest_reg,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic              pc_src,
    output logic [DATA_W-1:0] out_branch_target,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  taken_count
);
    import mips_pkg::*;

    logic              taken_in, taken_q, taken_d, valid_d, bubble, capture, trap;
    memwb_ctrl_t       ctrl_in, ctrl_q, ctrl_d;
    logic [DATA_W-1:0] alu_d, store_d, tgt_d;
    logic [REG_W-1:0]  dest_d;
    logic [CNT_W-1:0]  cnt_d;

    branch_resolve u_branch_resolve (
        .branch    (branch),
        .zero      (alu_zero),
        .branch_ne (branch_ne),
        .taken     (taken_in)
    );

    // flush beats stall; an unstalled taken branch squashes the wrong-path slot behind it
    assign bubble  = flush | (~stall & pc_src);
    assign capture = ~flush & ~stall & ~pc_src;

`ifdef EX_MEM_OVF_TRAP_EN
    assign trap = in_valid & trap_en & alu_overflow;
`else
    assign trap = 1'b0;
`endif

    assign ctrl_in = '{
        mem_read:   mem_read  & in_valid & ~trap,
        mem_write:  mem_write & in_valid & ~trap,
        reg_write:  reg_write & in_valid & (dest_reg != '0) & ~trap,
        mem_to_reg: mem_to_reg & in_valid
    };

    // next state: bubble, hold or capture; the counter only moves on a taken capture
    always_comb begin
        valid_d = capture ? in_valid : (bubble ? 1'b0 : out_valid);
        ctrl_d  = capture ? ctrl_in : (bubble ? '0 : ctrl_q);
        alu_d   = capture ? alu_result : (bubble ? '0 : out_alu_result);
        store_d = capture ? rt_data : (bubble ? '0 : out_store_data);
        dest_d  = capture ? dest_reg : (bubble ? '0 : out_dest_reg);
        tgt_d   = capture ? branch_target : (bubble ? '0 : out_branch_target);
        taken_d = capture ? (in_valid & taken_in) : (bubble ? 1'b0 : taken_q);
        cnt_d   = (capture & in_valid & taken_in & (taken_count != '1)) ? taken_count + CNT_W'(1) : taken_count;
    end

    // stage registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            ctrl_q            <= '0;
            out_alu_result    <= '0;
            out_store_data    <= '0;
            out_dest_reg      <= '0;
            out_branch_target <= '0;
            taken_q           <= 1'b0;
            taken_count       <= '0;
        end else begin
            out_valid         <= valid_d;
            ctrl_q            <= ctrl_d;
            out_alu_result    <= alu_d;
            out_store_data    <= store_d;
            out_dest_reg      <= dest_d;
            out_branch_target <= tgt_d;
            taken_q           <= taken_d;
            taken_count       <= cnt_d;
        end
    end

`ifdef EX_MEM_OVF_TRAP_EN
    // sticky overflow exception with the faulting PC, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_overflow <= 1'b0;
            epc          <= '0;
        end else if (capture & trap) begin
            exc_overflow <= 1'b1;
            epc          <= pc_in;
        end
    end
`endif

    assign out_mem_read   = ctrl_q.mem_read;
    assign out_mem_write  = ctrl_q.mem_write;
    assign out_reg_write  = ctrl_q.reg_write;
    assign out_mem_to_reg = ctrl_q.mem_to_reg;
    assign pc_src         = out_valid & taken_q;
    assign fwd_valid      = out_valid & ctrl_q.reg_write & ~ctrl_q.mem_read;
    assign fwd_reg        = out_dest_reg;
    assign fwd_data       = out_alu_result;
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed table-driven bench for ex_mem_stage plus reset, saturation and trap sequences
module tb_ex_mem_stage;
    localparam int CW = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid, alu_zero, mem_read, mem_write, reg_write, mem_to_reg;
    logic        branch, branch_ne, stall, flush;
    logic [31:0] alu_result, rt_data, branch_target;
    logic [4:0]  dest_reg;
    logic        out_valid, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg;
    logic        pc_src, fwd_valid;
    logic [31:0] out_alu_result, out_store_data, out_branch_target, fwd_data;
    logic [4:0]  out_dest_reg, fwd_reg;
    logic [CW-1:0] taken_count;
`ifdef EX_MEM_OVF_TRAP_EN
    logic        alu_overflow, trap_en, exc_overflow;
    logic [31:0] pc_in, epc;
`endif

    int checks = 0;
    int failures = 0;

    ex_mem_stage #(.DATA_W(32), .REG_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_result(alu_result), .alu_zero(alu_zero),
        .rt_data(rt_data), .dest_reg(dest_reg), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .branch(branch), .branch_ne(branch_ne),
        .branch_target(branch_target), .stall(stall), .flush(flush),
`ifdef EX_MEM_OVF_TRAP_EN
        .alu_overflow(alu_overflow), .trap_en(trap_en), .pc_in(pc_in),
        .exc_overflow(exc_overflow), .epc(epc),
`endif
        .out_valid(out_valid), .out_alu_result(out_alu_result), .out_store_data(out_store_data),
        .out_dest_reg(out_dest_reg), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg), .pc_src(pc_src),
        .out_branch_target(out_branch_target), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
        .fwd_data(fwd_data), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic iv; logic [31:0] alu; logic z; logic [31:0] rt; logic [4:0] dest; logic [3:0] ctl;
        logic br; logic bne; logic [31:0] tgt; logic st; logic fl;
        logic ev; logic [31:0] ealu; logic [31:0] est; logic [4:0] edest; logic [3:0] ectl;
        logic epcs; logic [31:0] etgt; logic efwd; logic [3:0] ecnt;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = v.iv; alu_result = v.alu; alu_zero = v.z; rt_data = v.rt; dest_reg = v.dest;
        {mem_read, mem_write, reg_write, mem_to_reg} = v.ctl;
        branch = v.br; branch_ne = v.bne; branch_target = v.tgt; stall = v.st; flush = v.fl;
    endtask

    task automatic idle();
        in_valid = 0; alu_result = 0; alu_zero = 0; rt_data = 0; dest_reg = 0;
        {mem_read, mem_write, reg_write, mem_to_reg} = 4'b0;
        branch = 0; branch_ne = 0; branch_target = 0; stall = 0; flush = 0;
`ifdef EX_MEM_OVF_TRAP_EN
        alu_overflow = 0; trap_en = 0; pc_in = 0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //           iv alu           z  rt       dest ctl      br bne tgt           st fl  ev ealu          est      edest ectl    pcs etgt          fwd cnt
        vecs[0]  = '{1, 32'h80000000, 0, 32'h1234, 8, 4'b0010, 0, 0, 32'h0,        0, 0,  1, 32'h80000000, 32'h1234, 8, 4'b0010, 0, 32'h0,        1, 0};
        vecs[1]  = '{1, 32'h0,        1, 32'h0,    0, 4'b0000, 1, 0, 32'h00400040, 0, 0,  1, 32'h0,        32'h0,    0, 4'b0000, 1, 32'h00400040, 0, 1};
        vecs[2]  = '{1, 32'h55,       0, 32'h66,   3, 4'b0010, 0, 0, 32'h99,       0, 0,  0, 32'h0,        32'h0,    0, 4'b0000, 0, 32'h0,        0, 1};
        vecs[3]  = '{1, 32'h0,        1, 32'h0,    0, 4'b0000, 1, 1, 32'h100,      0, 0,  1, 32'h0,        32'h0,    0, 4'b0000, 0, 32'h100,      0, 1};
        vecs[4]  = '{1, 32'h77,       0, 32'h0,    0, 4'b0010, 0, 0, 32'h0,        0, 0,  1, 32'h77,       32'h0,    0, 4'b0000, 0, 32'h0,        0, 1};
        vecs[5]  = '{1, 32'h2,        0, 32'h5,    9, 4'b0010, 0, 0, 32'h0,        0, 0,  1, 32'h2,        32'h5,    9, 4'b0010, 0, 32'h0,        1, 1};
        vecs[6]  = '{1, 32'hdead,     1, 32'h1,    1, 4'b1111, 1, 0, 32'h44,       1, 0,  1, 32'h2,        32'h5,    9, 4'b0010, 0, 32'h0,        1, 1};
        vecs[7]  = vecs[6];
        vecs[8]  = vecs[6];
        vecs[9]  = '{1, 32'hdead,     1, 32'h1,    1, 4'b1111, 1, 0, 32'h44,       1, 1,  0, 32'h0,        32'h0,    0, 4'b0000, 0, 32'h0,        0, 1};
        vecs[10] = '{0, 32'h33,       0, 32'h7,    4, 4'b1111, 1, 1, 32'h88,       0, 0,  0, 32'h33,       32'h7,    4, 4'b0000, 0, 32'h88,       0, 1};
        vecs[11] = '{1, 32'h1000,     0, 32'h0,    5, 4'b1011, 0, 0, 32'h0,        0, 0,  1, 32'h1000,     32'h0,    5, 4'b1011, 0, 32'h0,        0, 1};
        vecs[12] = '{1, 32'h0,        0, 32'h0,    0, 4'b0000, 1, 1, 32'h00400080, 0, 0,  1, 32'h0,        32'h0,    0, 4'b0000, 1, 32'h00400080, 0, 2};
        vecs[13] = '{1, 32'habc,      1, 32'h0,    0, 4'b0000, 1, 0, 32'h123,      1, 0,  1, 32'h0,        32'h0,    0, 4'b0000, 1, 32'h00400080, 0, 2};
        vecs[14] = vecs[13];
        vecs[15] = '{1, 32'h5,        1, 32'h0,    6, 4'b0010, 1, 0, 32'h200,      0, 0,  0, 32'h0,        32'h0,    0, 4'b0000, 0, 32'h0,        0, 2};
        vecs[16] = '{1, 32'h20,       0, 32'habcd, 0, 4'b0100, 0, 0, 32'h0,        0, 0,  1, 32'h20,       32'habcd, 0, 4'b0100, 0, 32'h0,        0, 2};

        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset pc_src", 32'(pc_src), 0);
        chk("reset fwd_valid", 32'(fwd_valid), 0);
        chk("reset taken_count", 32'(taken_count), 0);
        chk("reset out_alu_result", out_alu_result, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("v%0d out_alu_result", i), out_alu_result, vecs[i].ealu);
            chk($sformatf("v%0d out_store_data", i), out_store_data, vecs[i].est);
            chk($sformatf("v%0d out_dest_reg", i), 32'(out_dest_reg), 32'(vecs[i].edest));
            chk($sformatf("v%0d ctrl", i), 32'({out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg}), 32'(vecs[i].ectl));
            chk($sformatf("v%0d pc_src", i), 32'(pc_src), 32'(vecs[i].epcs));
            chk($sformatf("v%0d out_branch_target", i), out_branch_target, vecs[i].etgt);
            chk($sformatf("v%0d fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].efwd));
            chk($sformatf("v%0d fwd_reg", i), 32'(fwd_reg), 32'(vecs[i].edest));
            chk($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].ealu);
            chk($sformatf("v%0d taken_count", i), 32'(taken_count), 32'(vecs[i].ecnt));
            @(negedge clk);
        end

        // taken-branch counter climbs by one per taken capture and sticks at all ones
        do_reset();
        for (int i = 0; i < 20; i++) begin
            idle();
            in_valid = 1; branch = 1; alu_zero = 1;
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d taken_count", i), 32'(taken_count), (i + 1 < 15) ? 32'(i + 1) : 32'd15);
            @(negedge clk);
            idle();
            @(negedge clk);
        end

        // asynchronous reset between edges while a taken branch is in the stage
        do_reset();
        idle();
        in_valid = 1; branch = 1; alu_zero = 1; branch_target = 32'h00400040;
        @(posedge clk);
        #1;
        chk("async pre pc_src", 32'(pc_src), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async pc_src", 32'(pc_src), 0);
        chk("async out_valid", 32'(out_valid), 0);
        chk("async taken_count", 32'(taken_count), 0);
        chk("async out_branch_target", out_branch_target, 0);
        @(negedge clk);
        idle();
        rst = 1'b0;

`ifdef EX_MEM_OVF_TRAP_EN
        // overflowing signed add traps: writes suppressed, exception and EPC latched
        @(negedge clk);
        idle();
        in_valid = 1; alu_result = 32'h80000000; reg_write = 1; mem_write = 1; dest_reg = 2;
        alu_overflow = 1; trap_en = 1; pc_in = 32'h00400010;
        @(posedge clk);
        #1;
        chk("trap out_valid", 32'(out_valid), 1);
        chk("trap out_reg_write", 32'(out_reg_write), 0);
        chk("trap out_mem_write", 32'(out_mem_write), 0);
        chk("trap exc_overflow", 32'(exc_overflow), 1);
        chk("trap epc", epc, 32'h00400010);
        @(negedge clk);
        idle();
        in_valid = 1; reg_write = 1; dest_reg = 3; pc_in = 32'h00400014;
        @(posedge clk);
        #1;
        chk("post-trap out_reg_write", 32'(out_reg_write), 1);
        chk("post-trap exc_overflow", 32'(exc_overflow), 1);
        chk("post-trap epc", epc, 32'h00400010);
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline boundary directly downstream of the 32-bit ALU in the 5-stage MIPS core.
- Registers the ALU result, zero flag, store data, destination register and MEM/WB control bits.
- Resolves beq/bne from the ALU zero flag and drives pc_src and the branch target to the fetch stage.
- Handles stall (hold), flush (bubble) and self-squash of the wrong-path slot; exports a forwarding tap.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data, branch target)
- REG_W, 5, register-index width
- CNT_W, 16, width of the taken-branch saturating counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  EX slot holds a real instruction
- alu_result  in  DATA_W  ALU output
- alu_zero  in  1  ALU zero flag
- rt_data  in  DATA_W  store data
- dest_reg  in  REG_W  write-back register index
- mem_read, mem_write, reg_write, mem_to_reg  in  1 each  control bits from ID/EX
- branch, branch_ne  in  1 each  beq / bne qualifiers
- branch_target  in  DATA_W  computed PC target
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble
- out_valid  out  1  registered valid
- out_alu_result, out_store_data  out  DATA_W  registered data
- out_dest_reg  out  REG_W  registered index
- out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  out  1 each  registered controls
- pc_src  out  1  taken branch in this stage
- out_branch_target  out  DATA_W  registered target
- fwd_valid  out  1  out_valid & out_reg_write & ~out_mem_read
- fwd_reg  out  REG_W  equals out_dest_reg
- fwd_data  out  DATA_W  equals out_alu_result
- taken_count  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (asynchronous, active-high): all registered outputs and taken_count go to 0, so pc_src=0 and fwd_valid=0. Reset mid-stall or mid-branch clears everything immediately.
- Each rising edge applies exactly one action, first match wins:
  1. flush: load a bubble (valid and all controls 0; data fields 0).
  2. stall: hold every register, including taken_count.
  3. squash: if pc_src=1, load a bubble regardless of in_valid (the slot is wrong-path).
  4. capture: load all inputs; valid = in_valid; control bits are ANDed with in_valid.
- Register-0 write suppression on capture: out_reg_write = reg_write & in_valid & (dest_reg != 0).
- Taken bit on capture: in_valid & branch & (alu_zero XOR branch_ne).
- pc_src = out_valid & taken bit. It is driven from registered state, so latency from EX to pc_src is 1 cycle. It stays high for as long as stall holds the stage.
- Flush and stall asserted together: flush wins.
- taken_count increments by 1 on a capture with taken bit = 1 and saturates at all ones; it does not wrap.
- No combinational path from any input to any output.

Optional Feature:
- Macro: EX_MEM_OVF_TRAP_EN.
- Enabled:
  - Extra inputs: alu_overflow (1), trap_en (1, signed add/sub), pc_in (DATA_W).
  - Extra outputs: exc_overflow (1) and epc (DATA_W).
  - On a capture with in_valid & trap_en & alu_overflow:
    - out_reg_write, out_mem_write and out_mem_read are forced to 0.
    - exc_overflow becomes 1 and epc becomes pc_in.
  - exc_overflow stays set until rst.
- Disabled: these ports are absent and there is no trap suppression.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and REG_W constants;
  - ALU op encodings (ADD=3'b010, SUB=3'b110);
  - a packed mem/wb control struct {mem_read, mem_write, reg_write, mem_to_reg}.
- One sub-module, branch_resolve: combinational taken = branch & (zero ^ branch_ne). It is shared with a future early-branch unit in ID.

Test Plan:
- Add capture: alu_result=0x80000000, rt_data=0x1234, dest_reg=8, reg_write=1, in_valid=1 → next cycle out_alu_result=0x80000000, fwd_valid=1, fwd_reg=8, pc_src=0.
- beq taken: branch=1, branch_ne=0, alu_zero=1, branch_target=0x00400040 → next cycle pc_src=1, out_branch_target=0x00400040, taken_count=1. Following cycle out_valid=0 (squash) even though in_valid=1.
- bne not taken: branch=1, branch_ne=1, alu_zero=1 → pc_src=0, taken_count unchanged. A capture with dest_reg=0 and reg_write=1 gives out_reg_write=0.
- Stall then flush: capture 0x2, then stall=1 for 3 cycles → outputs hold 0x2. Then stall=1 and flush=1 together → out_valid=0 and all controls 0.
- Async reset mid-operation: assert rst between clock edges while pc_src=1 → pc_src, out_valid and taken_count go to 0 immediately, without waiting for a clock edge.
- With EX_MEM_OVF_TRAP_EN: 0x7FFFFFFF+1 with alu_overflow=1, trap_en=1, reg_write=1, pc_in=0x00400010 → out_reg_write=0, exc_overflow=1, epc=0x00400010.
